ps2_host_tx: RTL and testbench

Host-to-device PS/2 transmitter. It sends one command byte per bus write to the attached keyboard (LED set 0xED, reset 0xFF, typematic 0xF3 and so on). It generates the clock-inhibit / request-to-send sequence, shifts the frame out on device-generated clock edges, and checks the device ACK. It sits beside the PS/2 receiver on the same kclk/kdata pins, drives them open-drain through output enables, and raises `active` so the receiver path ignores the lines while a transmission is in flight.

---
 rtl/ps2_host_tx.sv | 195 +++++++++++++++++++
 tb/tb_ps2_host_tx.sv | 324 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 command transmitter: inhibit / request-to-send, frame shift-out on
// device clock falls, ACK check with timeout. Drives kclk/kdata open-drain via output enables.
module ps2_host_tx #(
  parameter int unsigned INHIBIT_CYCLES = 5000,
  parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [2:0]  a,
  input  logic [31:0] d,
  input  logic        we,
  output logic [31:0] spo,
  output logic        irq,
  output logic        active,
  input  logic        kclk,
  input  logic        kdata,
  output logic        kclk_oe,
  output logic        kdata_oe
);

  typedef enum logic [2:0] {
    IDLE,
    INHIBIT,
    RELEASE,
    SHIFT,
    ACK,
    WAITIDLE,
    DONE
  } state_t;

  localparam logic [31:0] INH_LAST = INHIBIT_CYCLES - 1;
  localparam logic [31:0] INH_PRE  = INHIBIT_CYCLES - 2;
  localparam logic [31:0] TO_LIMIT = TIMEOUT_CYCLES;

  state_t      state_reg;
  logic [7:0]  shift_reg;
  logic [7:0]  byte_reg;
  logic        parity_reg;
  logic [3:0]  bit_cnt_reg;
  logic [31:0] inhibit_cnt_reg;
  logic [31:0] timeout_cnt_reg;
  logic        nack_reg;
  logic        timeout_reg;
  logic        kclk_prev_reg;

  logic [1:0]  pin_raw;
  logic [1:0]  pin_sync;
  logic        kclk_sync;
  logic        kdata_sync;
  logic        fe;
  logic        timed;
  logic        unused_bits;

  assign pin_raw = {kdata, kclk};

  // Both pins idle high, so the synchronizers come out of reset at 1 to avoid a false edge.
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_sync
      logic meta_reg;
      logic sync_reg;
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          meta_reg <= 1'b1;
          sync_reg <= 1'b1;
        end else begin
          meta_reg <= pin_raw[gi];
          sync_reg <= meta_reg;
        end
      end
      assign pin_sync[gi] = sync_reg;
    end
  endgenerate

  assign kclk_sync  = pin_sync[0];
  assign kdata_sync = pin_sync[1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      kclk_prev_reg <= 1'b1;
    end else begin
      kclk_prev_reg <= kclk_sync;
    end
  end

  assign fe    = kclk_prev_reg & ~kclk_sync;
  assign timed = (state_reg == RELEASE) || (state_reg == SHIFT) ||
                 (state_reg == ACK) || (state_reg == WAITIDLE);

  assign spo         = {active, 21'd0, nack_reg, timeout_reg, byte_reg};
  assign unused_bits = ^d[31:8];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg       <= IDLE;
      shift_reg       <= 8'd0;
      byte_reg        <= 8'd0;
      parity_reg      <= 1'b0;
      bit_cnt_reg     <= 4'd0;
      inhibit_cnt_reg <= 32'd0;
      timeout_cnt_reg <= 32'd0;
      nack_reg        <= 1'b0;
      timeout_reg     <= 1'b0;
      kclk_oe         <= 1'b0;
      kdata_oe        <= 1'b0;
      irq             <= 1'b0;
      active          <= 1'b0;
    end else begin
      irq <= 1'b0;
      if (timed && (timeout_cnt_reg == TO_LIMIT)) begin
        // Device went silent: let go of both lines and report.
        timeout_reg <= 1'b1;
        kclk_oe     <= 1'b0;
        kdata_oe    <= 1'b0;
        irq         <= 1'b1;
        state_reg   <= DONE;
      end else begin
        if (timed && (timeout_cnt_reg != 32'hFFFF_FFFF)) begin
          timeout_cnt_reg <= timeout_cnt_reg + 32'd1;
        end
        case (state_reg)
          IDLE: begin
            kclk_oe  <= 1'b0;
            kdata_oe <= 1'b0;
            if (we && (a == 3'd0)) begin
              shift_reg       <= d[7:0];
              byte_reg        <= d[7:0];
              parity_reg      <= ~^d[7:0];
              nack_reg        <= 1'b0;
              timeout_reg     <= 1'b0;
              inhibit_cnt_reg <= 32'd0;
              kclk_oe         <= 1'b1;
              kdata_oe        <= (INHIBIT_CYCLES == 1);
              active          <= 1'b1;
              state_reg       <= INHIBIT;
            end
          end
          INHIBIT: begin
            inhibit_cnt_reg <= inhibit_cnt_reg + 32'd1;
            if (inhibit_cnt_reg == INH_PRE) begin
              kdata_oe <= 1'b1;
            end
            if (inhibit_cnt_reg == INH_LAST) begin
              kclk_oe         <= 1'b0;
              kdata_oe        <= 1'b1;
              timeout_cnt_reg <= 32'd0;
              state_reg       <= RELEASE;
            end
          end
          RELEASE: begin
            bit_cnt_reg <= 4'd0;
            state_reg   <= SHIFT;
          end
          SHIFT: begin
            if (fe) begin
              bit_cnt_reg <= bit_cnt_reg + 4'd1;
              if (bit_cnt_reg <= 4'd7) begin
                kdata_oe  <= ~shift_reg[0];
                shift_reg <= {1'b0, shift_reg[7:1]};
              end else if (bit_cnt_reg == 4'd8) begin
                kdata_oe <= ~parity_reg;
              end else begin
                kdata_oe  <= 1'b0;
                state_reg <= ACK;
              end
            end
          end
          ACK: begin
            if (fe) begin
              nack_reg  <= kdata_sync;
              state_reg <= WAITIDLE;
            end
          end
          WAITIDLE: begin
            // Device may stretch the ACK; finish only once both lines are back to idle.
            if (kclk_sync && kdata_sync) begin
              irq       <= 1'b1;
              state_reg <= DONE;
            end
          end
          DONE: begin
            active    <= 1'b0;
            state_reg <= IDLE;
          end
          default: begin
            kclk_oe   <= 1'b0;
            kdata_oe  <= 1'b0;
            active    <= 1'b0;
            state_reg <= IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: a behavioural PS/2 device plus a timeline model of the host outputs,
// compared every cycle, with literal expectations for the directed frames.
module tb_ps2_host_tx;

  localparam int INH = 50;
  localparam int TO  = 200;

  localparam int S_KCLK  = 0;
  localparam int S_KDATA = 1;
  localparam int S_ACT   = 2;
  localparam int S_IRQ   = 3;
  localparam int S_NACK  = 4;
  localparam int S_TO    = 5;
  localparam int S_BYTE  = 6;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [2:0]  a = 3'd0;
  logic [31:0] d = 32'd0;
  logic        we = 1'b0;
  logic [31:0] spo;
  logic        irq;
  logic        active;
  logic        kclk_oe;
  logic        kdata_oe;
  logic        dev_clk_low = 1'b0;
  logic        dev_data_low = 1'b0;
  wire         kclk_line  = ~(kclk_oe | dev_clk_low);
  wire         kdata_line = ~(kdata_oe | dev_data_low);

  ps2_host_tx #(.INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TO)) dut (
    .clk      (clk),
    .rst      (rst),
    .a        (a),
    .d        (d),
    .we       (we),
    .spo      (spo),
    .irq      (irq),
    .active   (active),
    .kclk     (kclk_line),
    .kdata    (kdata_line),
    .kclk_oe  (kclk_oe),
    .kdata_oe (kdata_oe)
  );

  always #5 clk = ~clk;

  typedef struct {
    int cyc;
    int sig;
    int val;
  } ev_t;

  ev_t evq[$];
  int  exp_v[7];
  int  cyc = 0;
  int  tests = 0;
  int  fails = 0;
  int  irq_count = 0;
  int  fail_prints = 0;
  bit  chk_en = 1'b0;

  initial begin
    forever begin
      @(posedge clk);
      cyc = cyc + 1;
    end
  end

  task automatic push(input int c, input int s, input int v);
    ev_t e;
    e.cyc = c;
    e.sig = s;
    e.val = v;
    evq.push_back(e);
  endtask

  task automatic clear_model();
    evq.delete();
    for (int i = 0; i < 7; i++) exp_v[i] = 0;
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] req);
    tests = tests + 1;
    if (got !== req) begin
      fails = fails + 1;
      $display("FAIL %s: got %h, required %h", name, got, req);
    end
  endtask

  function automatic logic [10:0] frame_of(input logic [7:0] b);
    return {1'b1, ~^b, b, 1'b0};
  endfunction

  // Per-cycle comparison against the output timeline.
  initial begin
    logic [31:0] exp_spo;
    int i;
    forever begin
      @(negedge clk);
      #1;
      if (irq === 1'b1) irq_count = irq_count + 1;
      if (chk_en) begin
        i = 0;
        while (i < evq.size()) begin
          if (evq[i].cyc <= cyc) begin
            exp_v[evq[i].sig] = evq[i].val;
            evq.delete(i);
          end else begin
            i = i + 1;
          end
        end
        exp_spo = {exp_v[S_ACT] != 0, 21'd0, exp_v[S_NACK] != 0, exp_v[S_TO] != 0, 8'(exp_v[S_BYTE])};
        tests = tests + 1;
        if (kclk_oe !== (exp_v[S_KCLK] != 0) || kdata_oe !== (exp_v[S_KDATA] != 0) ||
            active !== (exp_v[S_ACT] != 0) || irq !== (exp_v[S_IRQ] != 0) || spo !== exp_spo) begin
          fails = fails + 1;
          if (fail_prints < 12) begin
            fail_prints = fail_prints + 1;
            $display("FAIL cycle %0d outputs: got kclk_oe=%b kdata_oe=%b active=%b irq=%b spo=%h, required %0d %0d %0d %0d %h",
                     cyc, kclk_oe, kdata_oe, active, irq, spo, exp_v[S_KCLK], exp_v[S_KDATA],
                     exp_v[S_ACT], exp_v[S_IRQ], exp_spo);
          end
        end
      end
    end
  end

  task automatic bus_write(input logic [2:0] aa, input logic [31:0] dd, output int w);
    @(negedge clk);
    a  = aa;
    d  = dd;
    we = 1'b1;
    @(negedge clk);
    we = 1'b0;
    a  = 3'd0;
    d  = 32'd0;
    w  = cyc;
  endtask

  // Accepted write at cycle w: inhibit for INH cycles, start bit on the last one, then release.
  task automatic model_accept(input int w, input logic [7:0] b);
    push(w, S_ACT, 1);
    push(w, S_KCLK, 1);
    push(w, S_BYTE, int'(b));
    push(w, S_NACK, 0);
    push(w, S_TO, 0);
    push(w + INH - 1, S_KDATA, 1);
    push(w + INH, S_KCLK, 0);
  endtask

  // Device: samples a bit at each clock release, host answers a fall 3 cycles later.
  task automatic device(input logic [7:0] b, input int h, input int d0, input bit ack,
                        input int hold, input int abort_k, output logic [10:0] bits);
    logic [10:0] fr;
    fr   = frame_of(b);
    bits = 11'd0;
    repeat (d0) @(negedge clk);
    bits[0] = kdata_line;
    for (int k = 1; k <= 10; k++) begin
      dev_clk_low = 1'b1;
      push(cyc + 3, S_KDATA, fr[k] ? 0 : 1);
      if (k == abort_k) return;
      repeat (h) @(negedge clk);
      dev_clk_low = 1'b0;
      bits[k] = kdata_line;
      if (k == 10) dev_data_low = ack;
      repeat (h) @(negedge clk);
    end
    dev_clk_low = 1'b1;
    if (!ack) push(cyc + 3, S_NACK, 1);
    repeat (h) @(negedge clk);
    dev_clk_low = 1'b0;
    if (ack) begin
      repeat (hold) @(negedge clk);
      dev_data_low = 1'b0;
    end
    push(cyc + 3, S_IRQ, 1);
    push(cyc + 4, S_IRQ, 0);
    push(cyc + 4, S_ACT, 0);
  endtask

  task automatic run_frame(input logic [7:0] b, input int h, input int d0, input bit ack,
                           input int hold, output logic [10:0] bits);
    int w;
    int irq0;
    logic [31:0] r32;
    irq0 = irq_count;
    r32  = $urandom;
    bus_write(3'd0, {r32[31:8], b}, w);
    model_accept(w, b);
    repeat (INH) @(negedge clk);
    device(b, h, d0, ack, hold, 0, bits);
    repeat (6) @(negedge clk);
    check("frame bits", 32'(bits), 32'(frame_of(b)));
    check("irq pulses", irq_count - irq0, 1);
    check("nack flag", 32'(spo[9]), 32'(!ack));
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [10:0] bits;
    logic [7:0]  b;
    int w;
    int w2;
    int irq0;
    int h;
    int d0;
    int hold;
    bit ack;

    clear_model();
    #2 rst = 1'b1;
    repeat (3) @(negedge clk);
    check("reset kclk_oe", 32'(kclk_oe), 0);
    check("reset kdata_oe", 32'(kdata_oe), 0);
    check("reset irq", 32'(irq), 0);
    check("reset active", 32'(active), 0);
    check("reset spo", spo, 0);
    rst    = 1'b0;
    chk_en = 1'b1;

    run_frame(8'hED, 5, 3, 1'b1, 0, bits);
    check("ED bits literal", 32'(bits), 32'h7DA);
    check("spo after ED", spo, 32'h0000_00ED);

    run_frame(8'h01, 5, 3, 1'b0, 0, bits);
    check("01 parity bit", 32'(bits[9]), 0);
    check("01 nack", 32'(spo[9]), 1);
    check("01 timeout", 32'(spo[8]), 0);

    // Device never clocks.
    irq0 = irq_count;
    bus_write(3'd0, 32'h0000_00FF, w);
    model_accept(w, 8'hFF);
    push(w + INH + TO + 1, S_KDATA, 0);
    push(w + INH + TO + 1, S_TO, 1);
    push(w + INH + TO + 1, S_IRQ, 1);
    push(w + INH + TO + 2, S_IRQ, 0);
    push(w + INH + TO + 2, S_ACT, 0);
    repeat (INH + TO) @(negedge clk);
    check("timeout not yet", 32'(spo[8]), 0);
    @(negedge clk);
    #2;
    check("timeout flag", 32'(spo[8]), 1);
    check("timeout oe", {30'd0, kclk_oe, kdata_oe}, 0);
    check("timeout irq", 32'(irq), 1);
    @(negedge clk);
    #2;
    check("timeout active", 32'(active), 0);
    check("timeout irq count", irq_count - irq0, 1);

    // Second write during SHIFT must be ignored.
    irq0 = irq_count;
    bus_write(3'd0, 32'h0000_00F3, w);
    model_accept(w, 8'hF3);
    repeat (INH) @(negedge clk);
    fork
      device(8'hF3, 5, 3, 1'b1, 0, 0, bits);
      begin
        repeat (30) @(negedge clk);
        bus_write(3'd0, 32'h0000_0020, w2);
      end
    join
    repeat (6) @(negedge clk);
    check("F3 frame bits", 32'(bits), 32'(frame_of(8'hF3)));
    check("F3 spo byte", 32'(spo[7:0]), 32'hF3);
    check("F3 irq count", irq_count - irq0, 1);

    bus_write(3'd5, 32'h0000_00AA, w);
    repeat (3) @(negedge clk);
    check("a!=0 ignored", spo, 32'h0000_00F3);

    // Reset in the middle of the D4 bit.
    bus_write(3'd0, 32'h0000_00ED, w);
    model_accept(w, 8'hED);
    repeat (INH) @(negedge clk);
    device(8'hED, 5, 3, 1'b1, 0, 5, bits);
    repeat (4) @(negedge clk);
    check("pre-reset kdata_oe", 32'(kdata_oe), 1);
    chk_en = 1'b0;
    #2 rst = 1'b1;
    #1;
    check("async reset kclk_oe", 32'(kclk_oe), 0);
    check("async reset kdata_oe", 32'(kdata_oe), 0);
    check("async reset spo", spo, 0);
    dev_clk_low  = 1'b0;
    dev_data_low = 1'b0;
    clear_model();
    repeat (3) @(negedge clk);
    rst    = 1'b0;
    chk_en = 1'b1;
    run_frame(8'hED, 6, 5, 1'b1, 0, bits);
    check("post-reset spo", spo, 32'h0000_00ED);

    // Device stretches kdata low after the ACK.
    run_frame(8'h5A, 5, 4, 1'b1, 50, bits);
    check("stretched ack nack", 32'(spo[9]), 0);

    for (int it = 0; it < 16; it++) begin
      b    = 8'($urandom);
      h    = $urandom_range(4, 6);
      d0   = $urandom_range(1, 8);
      ack  = 1'($urandom_range(0, 1));
      hold = $urandom_range(0, 40);
      if ($urandom_range(0, 3) == 0) begin
        bus_write(3'($urandom_range(1, 7)), $urandom, w);
      end
      run_frame(b, h, d0, ack, hold, bits);
      check("random spo byte", 32'(spo[7:0]), 32'(b));
    end

    repeat (4) @(negedge clk);
    check("model events drained", evq.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
